// File: rtl/tcp_sched_pkg.sv
// ----------------------------------------------------------------------------
// tcp_sched_pkg
// Shared types for the TCP per-flow pending-work scheduler.
//   sched_cmd_e  : per-flag command op (SET / CLEAR / NOP; raw value 3 acts as NOP)
//   SCHED_FLAG_* : bit positions of the default flag set
//   sched_cmd_t / sched_data_t : packed command / output records for the
//                  default configuration (16 flows, 3 flags)
// ----------------------------------------------------------------------------
package tcp_sched_pkg;

   typedef enum logic [1:0] {
      SCHED_SET   = 2'd0,
      SCHED_CLEAR = 2'd1,
      SCHED_NOP   = 2'd2
   } sched_cmd_e;

   localparam int SCHED_FLAG_DATA     = 0;
   localparam int SCHED_FLAG_ACK      = 1;
   localparam int SCHED_FLAG_RT       = 2;
   localparam int SCHED_NUM_FLAGS_DEF = 3;
   localparam int SCHED_NUM_FLOWS_DEF = 16;
   localparam int SCHED_FLOWID_W_DEF  = $clog2(SCHED_NUM_FLOWS_DEF);

   typedef struct packed {
      logic [SCHED_FLOWID_W_DEF-1:0]               flowid;
      sched_cmd_e [SCHED_NUM_FLAGS_DEF-1:0]        ops;
   } sched_cmd_t;

   typedef struct packed {
      logic [SCHED_FLOWID_W_DEF-1:0]  flowid;
      logic [SCHED_NUM_FLAGS_DEF-1:0] flags;
   } sched_data_t;

endpackage

// File: rtl/tcp_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// tcp_sched_rr_pick
// Combinational rotate-priority find-first. Searches i_req starting at i_ptr,
// upward, wrapping at NUM_FLOWS back to 0.
//   i_req : request vector, one bit per flow
//   i_ptr : search start index (always < NUM_FLOWS)
//   o_any : at least one request set
//   o_sel : index of the first request found
// ----------------------------------------------------------------------------
module tcp_sched_rr_pick #(
   parameter int NUM_FLOWS = 16,
   parameter int FLOWID_W  = $clog2(NUM_FLOWS)
) (
   input  logic [NUM_FLOWS-1:0] i_req,
   input  logic [FLOWID_W-1:0]  i_ptr,
   output logic                 o_any,
   output logic [FLOWID_W-1:0]  o_sel
);

   always_comb begin
      int idx;
      o_any = 1'b0;
      o_sel = '0;
      idx   = 0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
         // ptr and i are both below NUM_FLOWS, so one subtraction wraps
         idx = int'(i_ptr) + i;
         if (idx >= NUM_FLOWS) idx = idx - NUM_FLOWS;
         if (!o_any && i_req[idx]) begin
            o_any = 1'b1;
            o_sel = FLOWID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/tcp_flow_sched_table.sv
// ----------------------------------------------------------------------------
// tcp_flow_sched_table
// Per-flow pending-work table. Producers set/clear flags per flow through
// NUM_CMD_PORTS command ports; flows with any flag set are round-robined into
// a single output register handed to the TX packet generator (valid/ready).
//   clk, rst_n     : clock, async active-low reset
//   cmd_val        : per-port command valid
//   cmd_flowid     : per-port flow id, port p at [p*FLOWID_W +: FLOWID_W]
//   cmd_ops        : per-port per-flag op, port p flag k at [(p*NUM_FLAGS+k)*2 +: 2]
//   cmd_rdy        : commands accepted (1 every cycle out of reset)
//   sched_val/rdy  : output handshake
//   sched_flowid   : scheduled flow
//   sched_flags    : flag snapshot taken when the flow was loaded
//   pend_flow_cnt  : registered count of nonzero table rows
// ----------------------------------------------------------------------------
module tcp_flow_sched_table
   import tcp_sched_pkg::*;
#(
   parameter int NUM_FLOWS     = 16,
   parameter int FLOWID_W      = $clog2(NUM_FLOWS),
   parameter int NUM_FLAGS     = 3,
   parameter int NUM_CMD_PORTS = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_CMD_PORTS-1:0]             cmd_val,
   input  logic [NUM_CMD_PORTS*FLOWID_W-1:0]    cmd_flowid,
   input  logic [NUM_CMD_PORTS*NUM_FLAGS*2-1:0] cmd_ops,
   output logic                                 cmd_rdy,
   output logic                                 sched_val,
   output logic [FLOWID_W-1:0]                  sched_flowid,
   output logic [NUM_FLAGS-1:0]                 sched_flags,
   input  logic                                 sched_rdy,
   output logic [FLOWID_W:0]                    pend_flow_cnt
);

   logic [NUM_FLOWS-1:0][NUM_FLAGS-1:0] r_tbl;
   logic [NUM_FLOWS-1:0][NUM_FLAGS-1:0] w_tbl_nxt;
   logic [FLOWID_W-1:0]                 r_ptr;
   logic                                r_sched_val;
   logic [FLOWID_W-1:0]                 r_sched_flowid;
   logic [NUM_FLAGS-1:0]                r_sched_flags;
   logic [FLOWID_W:0]                   r_cnt;
   logic                                r_cmd_rdy;

   logic [NUM_FLOWS-1:0]                w_nz;
   logic                                w_any;
   logic [FLOWID_W-1:0]                 w_sel;
   logic                                w_load;
   logic [FLOWID_W:0]                   w_cnt;

   logic [FLOWID_W-1:0] w_cmd_fid [NUM_CMD_PORTS];
   logic                w_cmd_hit [NUM_CMD_PORTS];
   logic [1:0]          w_cmd_op  [NUM_CMD_PORTS][NUM_FLAGS];

   // ---- command port unpacking ----
   for (genvar p = 0; p < NUM_CMD_PORTS; p++) begin : g_port
      assign w_cmd_fid[p] = cmd_flowid[p*FLOWID_W +: FLOWID_W];
      // out-of-range flow ids are dropped entirely
      assign w_cmd_hit[p] = cmd_val[p] &&
                            ({1'b0, w_cmd_fid[p]} < (FLOWID_W+1)'(NUM_FLOWS));
      for (genvar k = 0; k < NUM_FLAGS; k++) begin : g_flag
         assign w_cmd_op[p][k] = cmd_ops[(p*NUM_FLAGS+k)*2 +: 2];
      end
   end

   // ---- candidate selection ----
   for (genvar f = 0; f < NUM_FLOWS; f++) begin : g_nz
      assign w_nz[f] = |r_tbl[f];
   end

   tcp_sched_rr_pick #(
      .NUM_FLOWS (NUM_FLOWS),
      .FLOWID_W  (FLOWID_W)
   ) u_pick (
      .i_req (w_nz),
      .i_ptr (r_ptr),
      .o_any (w_any),
      .o_sel (w_sel)
   );

   assign w_load = (!r_sched_val || sched_rdy) && w_any;

   // ---- next table: load clear first, then commands in port order ----
   // A SET arriving alongside the load of the same flow therefore survives
   // and the flow is rescheduled later.
   always_comb begin
      w_tbl_nxt = r_tbl;
      if (w_load) w_tbl_nxt[w_sel] = '0;
      for (int p = 0; p < NUM_CMD_PORTS; p++) begin
         if (w_cmd_hit[p]) begin
            for (int k = 0; k < NUM_FLAGS; k++) begin
               if (w_cmd_op[p][k] == 2'(SCHED_SET))
                  w_tbl_nxt[w_cmd_fid[p]][k] = 1'b1;
               else if (w_cmd_op[p][k] == 2'(SCHED_CLEAR))
                  w_tbl_nxt[w_cmd_fid[p]][k] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_cnt = '0;
      for (int f = 0; f < NUM_FLOWS; f++)
         w_cnt = w_cnt + {{FLOWID_W{1'b0}}, w_nz[f]};
   end

   // ---- state ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tbl          <= '0;
         r_ptr          <= '0;
         r_sched_val    <= 1'b0;
         r_sched_flowid <= '0;
         r_sched_flags  <= '0;
         r_cnt          <= '0;
         r_cmd_rdy      <= 1'b0;
      end else begin
         r_tbl     <= w_tbl_nxt;
         r_cnt     <= w_cnt;
         r_cmd_rdy <= 1'b1;
         if (w_load) begin
            r_sched_val    <= 1'b1;
            r_sched_flowid <= w_sel;
            r_sched_flags  <= r_tbl[w_sel];
            r_ptr          <= (w_sel == FLOWID_W'(NUM_FLOWS-1)) ? '0 : w_sel + 1'b1;
         end else if (sched_rdy) begin
            r_sched_val <= 1'b0;
         end
      end
   end

   assign cmd_rdy       = r_cmd_rdy;
   assign sched_val     = r_sched_val;
   assign sched_flowid  = r_sched_flowid;
   assign sched_flags   = r_sched_flags;
   assign pend_flow_cnt = r_cnt;

endmodule

// File: tb/tb_tcp_flow_sched_table.sv
module tb_tcp_flow_sched_table;

   localparam logic [5:0] NOP = 6'b101010;
   localparam logic [5:0] SD  = 6'b101000;  // SET data
   localparam logic [5:0] SA  = 6'b100010;  // SET ack
   localparam logic [5:0] SR  = 6'b001010;  // SET rt
   localparam logic [5:0] CR  = 6'b011010;  // CLEAR rt
   localparam logic [5:0] ALL = 6'b000000;  // SET every flag

   logic        clk, rst_n;
   logic [1:0]  cmd_val;
   logic [7:0]  cmd_flowid;
   logic [11:0] cmd_ops;
   logic        cmd_rdy, sched_val, sched_rdy;
   logic [3:0]  sched_flowid;
   logic [2:0]  sched_flags;
   logic [4:0]  pend_flow_cnt;

   logic [1:0]  c_val;
   logic [7:0]  c_fid;
   logic [11:0] c_ops;
   logic        c_cmdrdy, c_sval, c_rdy;
   logic [3:0]  c_sfid;
   logic [2:0]  c_sflags;
   logic [4:0]  c_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   tcp_flow_sched_table #(.NUM_FLOWS(16), .NUM_FLAGS(3), .NUM_CMD_PORTS(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .cmd_flowid(cmd_flowid),
      .cmd_ops(cmd_ops), .cmd_rdy(cmd_rdy), .sched_val(sched_val),
      .sched_flowid(sched_flowid), .sched_flags(sched_flags),
      .sched_rdy(sched_rdy), .pend_flow_cnt(pend_flow_cnt));

   tcp_flow_sched_table #(.NUM_FLOWS(12), .NUM_FLAGS(3), .NUM_CMD_PORTS(2)) u_dut12 (
      .clk(clk), .rst_n(rst_n), .cmd_val(c_val), .cmd_flowid(c_fid),
      .cmd_ops(c_ops), .cmd_rdy(c_cmdrdy), .sched_val(c_sval),
      .sched_flowid(c_sfid), .sched_flags(c_sflags),
      .sched_rdy(c_rdy), .pend_flow_cnt(c_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- comparison helper ----
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---- reference model: flags per flow, rotating pointer, one output slot ----
   bit [2:0] m_tbl [16];
   int       m_ptr, m_fid, m_cnt;
   bit       m_val;
   bit [2:0] m_flags;

   task automatic model_reset();
      foreach (m_tbl[f]) m_tbl[f] = '0;
      m_ptr = 0; m_fid = 0; m_cnt = 0; m_val = 0; m_flags = '0;
   endtask

   task automatic model_step();
      bit [2:0] nt [16];
      int sel, cnt, f, fid, op;
      sel = -1;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         f = (m_ptr + i) % 16;
         if (sel < 0 && m_tbl[f] != 0) sel = f;
         if (m_tbl[i] != 0) cnt++;
      end
      nt = m_tbl;
      if ((!m_val || sched_rdy) && sel >= 0) begin
         m_val = 1; m_fid = sel; m_flags = m_tbl[sel];
         nt[sel] = '0;
         m_ptr = (sel + 1) % 16;
      end else if (sched_rdy) begin
         m_val = 0;
      end
      for (int p = 0; p < 2; p++) begin
         fid = int'(cmd_flowid[p*4 +: 4]);
         if (cmd_val[p] && fid < 16)
            for (int k = 0; k < 3; k++) begin
               op = int'(cmd_ops[p*6 + k*2 +: 2]);
               if (op == 0) nt[fid][k] = 1'b1;
               else if (op == 1) nt[fid][k] = 1'b0;
            end
      end
      m_tbl = nt;
      m_cnt = cnt;
   endtask

   // ---- stimulus helpers (called at posedge+2) ----
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [1:0] v, input int f0, input logic [5:0] o0,
                        input int f1, input logic [5:0] o1, input logic rdy);
      cmd_val    = v;
      cmd_flowid = {4'(f1), 4'(f0)};
      cmd_ops    = {o1, o0};
      sched_rdy  = rdy;
   endtask

   // ---- directed vector table: one record per clock ----
   typedef struct {
      string      seq;
      bit         rst;
      logic [1:0] v;
      int         f0;
      logic [5:0] o0;
      int         f1;
      logic [5:0] o1;
      logic       rdy;
      logic       e_val;
      int         e_fid;
      int         e_flags;
      int         e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(string s, bit r, logic [1:0] v, int f0, logic [5:0] o0,
                               int f1, logic [5:0] o1, logic rdy,
                               logic ev, int ef, int efl, int ec);
      vec_t x;
      x.seq = s; x.rst = r; x.v = v; x.f0 = f0; x.o0 = o0; x.f1 = f1; x.o1 = o1;
      x.rdy = rdy; x.e_val = ev; x.e_fid = ef; x.e_flags = efl; x.e_cnt = ec;
      return x;
   endfunction

   initial begin
      logic [5:0] r0, r1;

      cmd_val = '0; cmd_flowid = '0; cmd_ops = {NOP, NOP}; sched_rdy = 1'b0;
      c_val = '0; c_fid = '0; c_ops = {NOP, NOP}; c_rdy = 1'b1;

      // basic
      vq.push_back(mk("basic", 1, 2'b01, 5, SD,  0, NOP, 1, 0, 0, 0, 0));
      vq.push_back(mk("basic", 0, 2'b00, 0, NOP, 0, NOP, 1, 1, 5, 1, 1));
      vq.push_back(mk("basic", 0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));
      // round robin, then wrap from ptr=8 back to flow 2
      vq.push_back(mk("rr",    1, 2'b11, 2, SA,  7, SA,  1, 0, 0, 0, 0));
      vq.push_back(mk("rr",    0, 2'b01, 3, SA,  0, NOP, 1, 1, 2, 2, 2));
      vq.push_back(mk("rr",    0, 2'b00, 0, NOP, 0, NOP, 1, 1, 3, 2, 2));
      vq.push_back(mk("rr",    0, 2'b00, 0, NOP, 0, NOP, 1, 1, 7, 2, 1));
      vq.push_back(mk("rr",    0, 2'b01, 2, SA,  0, NOP, 1, 0, 0, 0, 0));
      vq.push_back(mk("rr",    0, 2'b00, 0, NOP, 0, NOP, 1, 1, 2, 2, 1));
      vq.push_back(mk("rr",    0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));
      // port conflict: later port wins
      vq.push_back(mk("conf",  1, 2'b11, 4, SR,  4, CR,  1, 0, 0, 0, 0));
      vq.push_back(mk("conf",  0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));
      vq.push_back(mk("conf",  0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));
      vq.push_back(mk("conf",  0, 2'b11, 4, CR,  4, SR,  1, 0, 0, 0, 0));
      vq.push_back(mk("conf",  0, 2'b00, 0, NOP, 0, NOP, 1, 1, 4, 4, 1));
      vq.push_back(mk("conf",  0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));
      // backpressure: snapshot stays 001 while table gains ack
      vq.push_back(mk("bp",    1, 2'b01, 1, SD,  0, NOP, 0, 0, 0, 0, 0));
      vq.push_back(mk("bp",    0, 2'b00, 0, NOP, 0, NOP, 0, 1, 1, 1, 1));
      vq.push_back(mk("bp",    0, 2'b01, 1, SA,  0, NOP, 0, 1, 1, 1, 0));
      vq.push_back(mk("bp",    0, 2'b01, 1, SA,  0, NOP, 0, 1, 1, 1, 1));
      vq.push_back(mk("bp",    0, 2'b01, 1, SA,  0, NOP, 0, 1, 1, 1, 1));
      vq.push_back(mk("bp",    0, 2'b01, 1, SA,  0, NOP, 0, 1, 1, 1, 1));
      vq.push_back(mk("bp",    0, 2'b00, 0, NOP, 0, NOP, 0, 1, 1, 1, 1));
      vq.push_back(mk("bp",    0, 2'b00, 0, NOP, 0, NOP, 1, 1, 1, 2, 1));
      vq.push_back(mk("bp",    0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));
      // SET in the same cycle the flow is loaded
      vq.push_back(mk("race",  1, 2'b01, 6, SD,  0, NOP, 1, 0, 0, 0, 0));
      vq.push_back(mk("race",  0, 2'b01, 6, SD,  0, NOP, 1, 1, 6, 1, 1));
      vq.push_back(mk("race",  0, 2'b00, 0, NOP, 0, NOP, 1, 1, 6, 1, 1));
      vq.push_back(mk("race",  0, 2'b00, 0, NOP, 0, NOP, 1, 0, 0, 0, 0));

      // ---- power-on reset ----
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset sched_val", int'(sched_val), 0);
      chk("reset sched_flowid", int'(sched_flowid), 0);
      chk("reset sched_flags", int'(sched_flags), 0);
      chk("reset pend_flow_cnt", int'(pend_flow_cnt), 0);
      chk("reset cmd_rdy", int'(cmd_rdy), 0);
      #8 rst_n = 1'b1;
      @(posedge clk); #2;
      chk("post-reset cmd_rdy", int'(cmd_rdy), 1);
      chk("post-reset sched_val", int'(sched_val), 0);

      // ---- directed vectors ----
      foreach (vq[i]) begin
         if (vq[i].rst) do_reset();
         drive(vq[i].v, vq[i].f0, vq[i].o0, vq[i].f1, vq[i].o1, vq[i].rdy);
         tick();
         chk($sformatf("%s[%0d] sched_val", vq[i].seq, i), int'(sched_val), int'(vq[i].e_val));
         chk($sformatf("%s[%0d] pend_flow_cnt", vq[i].seq, i), int'(pend_flow_cnt), vq[i].e_cnt);
         if (vq[i].e_val) begin
            chk($sformatf("%s[%0d] sched_flowid", vq[i].seq, i), int'(sched_flowid), vq[i].e_fid);
            chk($sformatf("%s[%0d] sched_flags", vq[i].seq, i), int'(sched_flags), vq[i].e_flags);
         end
      end

      // ---- mid-operation reset with every flow pending ----
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(2'b11, 2*i, SD, 2*i+1, SD, 0);
         tick();
      end
      drive(2'b00, 0, NOP, 0, NOP, 0);
      tick();
      chk("midrst pre sched_val", int'(sched_val), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst sched_val", int'(sched_val), 0);
      chk("midrst sched_flowid", int'(sched_flowid), 0);
      chk("midrst sched_flags", int'(sched_flags), 0);
      chk("midrst pend_flow_cnt", int'(pend_flow_cnt), 0);
      chk("midrst cmd_rdy", int'(cmd_rdy), 0);
      #3 rst_n = 1'b1;
      sched_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("after midrst sched_val", int'(sched_val), 0);
         chk("after midrst pend_flow_cnt", int'(pend_flow_cnt), 0);
      end

      // ---- NUM_FLOWS=12: ids 12 and 13 are ignored ----
      do_reset();
      c_rdy = 1'b1;
      c_val = 2'b11; c_fid = {4'd12, 4'd13}; c_ops = {ALL, ALL};
      tick();
      c_val = 2'b00; c_ops = {NOP, NOP};
      chk("range12 sched_val", int'(c_sval), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("range12 sched_val", int'(c_sval), 0);
         chk("range12 pend_flow_cnt", int'(c_cnt), 0);
      end
      c_val = 2'b01; c_fid = {4'd0, 4'd11}; c_ops = {NOP, SD};
      tick();
      c_val = 2'b00; c_ops = {NOP, NOP};
      chk("range12 f11 early sched_val", int'(c_sval), 0);
      tick();
      chk("range12 f11 sched_val", int'(c_sval), 1);
      chk("range12 f11 sched_flowid", int'(c_sfid), 11);
      chk("range12 f11 sched_flags", int'(c_sflags), 1);
      chk("range12 f11 pend_flow_cnt", int'(c_cnt), 1);
      tick();
      chk("range12 drained sched_val", int'(c_sval), 0);

      // ---- randomized run against the reference model ----
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < 3; k++) begin
            r0[k*2 +: 2] = 2'($urandom_range(0, 3));
            r1[k*2 +: 2] = 2'($urandom_range(0, 3));
         end
         drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), r0,
               int'($urandom_range(0, 15)), r1, ($urandom_range(0, 3) != 0));
         model_step();
         tick();
         chk($sformatf("rnd[%0d] sched_val", c), int'(sched_val), int'(m_val));
         chk($sformatf("rnd[%0d] pend_flow_cnt", c), int'(pend_flow_cnt), m_cnt);
         chk($sformatf("rnd[%0d] cmd_rdy", c), int'(cmd_rdy), 1);
         if (m_val) begin
            chk($sformatf("rnd[%0d] sched_flowid", c), int'(sched_flowid), m_fid);
            chk($sformatf("rnd[%0d] sched_flags", c), int'(sched_flags), int'(m_flags));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
